uart_cfg: RTL and testbench
===========================

// Module: uart_cfg
// PURPOSE
//  Full-duplex UART with build-time frame format (data bits, parity, stop length) and FIFO depth,
//  and a run-time baud divisor. Adds sticky framing, parity and overrun error flags, plus busy status.
//  Contains its own baud tick generator, RX/TX FIFOs, receiver and transmitter; sits between the
//  board RX/TX pins and the host-side command/debug logic.
// PARAMETERS
//  DBIT      8   data bits per frame, 5..8, sent and received LSB first
//  PARITY    0   0=none, 1=even, 2=odd; adds one parity bit after the data bits
//  SB_TICK   16  stop-bit length in ticks: 16/24/32 = 1/1.5/2 stop bits
//  DVSR_BIT  11  width of the run-time divisor
//  FIFO_W    2   log2 of the depth of each FIFO (depth = 2**FIFO_W)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  dvsr         in   DVSR_BIT  baud divisor = f_clk/(16*baud) - 1
//  rx           in   1         serial input, asynchronous to clk
//  tx           out  1         serial output, idles high
//  rd_uart      in   1         pop the RX FIFO head
//  r_data       out  8         RX FIFO head; zero-extended when DBIT<8
//  rx_empty     out  1         RX FIFO empty
//  rx_full      out  1         RX FIFO full
//  wr_uart      in   1         push w_data into the TX FIFO
//  w_data       in   8         TX data; only bits [DBIT-1:0] are sent
//  tx_full      out  1         TX FIFO full
//  tx_empty     out  1         TX FIFO empty
//  tx_busy      out  1         transmitter is not idle
//  rx_busy      out  1         receiver is not idle
//  frame_err    out  1         sticky: stop bit sampled low
//  parity_err   out  1         sticky: parity mismatch
//  overrun_err  out  1         sticky: word received while RX FIFO was full
//  clr_err      in   1         clear all three sticky error flags
// BEHAVIOUR
//  Reset values
//  - tx=1; busy and error flags 0; rx_empty=tx_empty=1; rx_full=tx_full=0.
//  - FIFO pointers and the baud counter go to 0; both FSMs go to IDLE.
//  - r_data is don't-care while rx_empty=1.
//  Baud tick generator
//  - Counter runs 0..dvsr, then wraps; s_tick is high for one clk at count==dvsr.
//  - dvsr=0 gives a tick every clk. dvsr is used live: change it only while tx_busy=rx_busy=0.
//  Receiver (RX path)
//  - rx passes through a 2-FF synchroniser before use.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: a low on the synchronised rx enters START and clears the tick count.
//  - START: rx is sampled at tick 7. If high, this is a false start: return to IDLE, no word.
//    If low, clear the tick count and go to DATA.
//  - DATA: sample each bit at tick 15 of the bit, DBIT bits total.
//  - PARITY (only when PARITY!=0): sample the parity bit at tick 15.
//  - STOP: lasts SB_TICK ticks; rx is sampled at tick SB_TICK-1.
//  - At the end of STOP, a one-clk done pulse pushes the word, even if it had an error.
//  - Errors: stop bit low sets frame_err; parity mismatch sets parity_err.
//  - Overrun: if the RX FIFO is full at the done pulse, the word is dropped and overrun_err is set.
//  - clr_err clears the error flags; a set event in the same cycle wins.
//  Transmitter (TX path)
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - Leaves IDLE on the first s_tick with tx_empty=0, taking the FIFO head.
//  - Bit times: 16 ticks each for start, data and parity; SB_TICK ticks for stop.
//  - The FIFO is popped on the last stop tick, so the word in flight still occupies a FIFO slot.
//  - Back-to-back frames are allowed: a new frame can start on the next tick with no idle gap.
//  FIFOs (both RX and TX)
//  - First-word-fall-through: the head is valid combinationally while not empty.
//  - rd on empty is ignored; wr on full is ignored.
//  - rd and wr in the same cycle: when neither full nor empty, both happen and the count is
//    unchanged; when empty, only the write happens; when full, both happen.
//  - Flags update on the clock edge after the operation.
//  Reset during a frame
//  - Aborts the frame: tx goes high on the next edge and both FIFOs are flushed.
// TESTING
//  - Setup: dvsr=0 (16 clk/bit), DBIT=8, PARITY=1, SB_TICK=16, FIFO_W=2, tx looped back to rx.
//  - Loopback: write 0xA5 -> tx sends 0, 1010_0101 LSB first, parity 0, stop 1 (176 clk);
//    then rx_empty=0, r_data=0xA5, no error flags set.
//  - Parity error: drive rx with 0x01 and parity bit 0 -> word pushed, parity_err=1.
//    Then pulse clr_err -> parity_err=0.
//  - Framing error: drive rx with 0x3C and the stop bit low -> r_data=0x3C, frame_err=1.
//  - Glitch: a 5-clk low pulse on rx -> no word, rx_busy returns to 0, rx_empty stays 1.
//  - Overrun: receive 5 bytes 0x10..0x14 without reading -> rx_full=1, overrun_err=1;
//    reads return 0x10..0x13.
//  - TX full: 5 back-to-back writes -> tx_full=1 after the 4th write and the 5th is dropped;
//    4 frames are sent; after the last stop bit, tx_empty=1 and tx=1.
//    Reset in mid-frame -> tx=1 next clk and tx_empty=1.

Source files
------------

// File: rtl/uart_cfg.sv
// Full-duplex UART with build-time frame format, run-time baud divisor, FWFT RX/TX FIFOs
// and sticky framing / parity / overrun error flags.
//
// RX and TX FSM states:
//   state    | meaning
//   ST_IDLE  | line idle (RX: wait for low; TX: wait for tick with data queued)
//   ST_START | start bit (RX: confirm at mid-bit; TX: drive low 16 ticks)
//   ST_DATA  | DBIT data bits, LSB first, 16 ticks each
//   ST_PAR   | parity bit, only used when PARITY != 0
//   ST_STOP  | stop bit(s), SB_TICK ticks
module uart_cfg #(
  parameter int DBIT     = 8,
  parameter int PARITY   = 0,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DVSR_BIT-1:0] dvsr,
  input  logic                rx,
  output logic                tx,
  input  logic                rd_uart,
  output logic [7:0]          r_data,
  output logic                rx_empty,
  output logic                rx_full,
  input  logic                wr_uart,
  input  logic [7:0]          w_data,
  output logic                tx_full,
  output logic                tx_empty,
  output logic                tx_busy,
  output logic                rx_busy,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun_err,
  input  logic                clr_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  localparam logic [5:0]        TICK_MID  = 6'd7;
  localparam logic [5:0]        TICK_END  = 6'd15;
  localparam logic [5:0]        TICK_STOP = 6'(SB_TICK - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DBIT - 1);
  localparam logic [FIFO_W-1:0] PTR_ONE   = FIFO_W'(1);

  function automatic logic par_of(input logic [DBIT-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  // baud tick generator
  logic [DVSR_BIT-1:0] baud_cnt;
  logic                s_tick;

  assign s_tick = (baud_cnt == dvsr);

  always_ff @(posedge clk) begin
    if (reset)       baud_cnt <= '0;
    else if (s_tick) baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + DVSR_BIT'(1);
  end

  // FIFOs: index 0 = RX, index 1 = TX
  logic [1:0]      f_wr, f_rd, f_full, f_empty;
  logic [DBIT-1:0] f_din  [2];
  logic [DBIT-1:0] f_head [2];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DBIT-1:0]   mem [2**FIFO_W];
    logic [FIFO_W-1:0] wptr, rptr;
    logic              full_q, empty_q;
    logic              do_wr, do_rd;

    // a write into a full FIFO is accepted only when the head is popped in the same cycle
    assign do_wr = f_wr[g] && (!full_q || f_rd[g]);
    assign do_rd = f_rd[g] && !empty_q;

    always_ff @(posedge clk) begin
      if (do_wr) mem[wptr] <= f_din[g];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr    <= '0;
        rptr    <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        if (do_wr) wptr <= wptr + PTR_ONE;
        if (do_rd) rptr <= rptr + PTR_ONE;
        if (do_wr && !do_rd) begin
          empty_q <= 1'b0;
          full_q  <= ((wptr + PTR_ONE) == rptr);
        end else if (do_rd && !do_wr) begin
          full_q  <= 1'b0;
          empty_q <= ((rptr + PTR_ONE) == wptr);
        end
      end
    end

    assign f_full[g]  = full_q;
    assign f_empty[g] = empty_q;
    assign f_head[g]  = mem[rptr];
  end

  // rx synchroniser
  logic rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // receiver
  state_t          rx_state, rx_state_nx;
  logic [5:0]      rx_tick, rx_tick_nx;
  logic [2:0]      rx_n, rx_n_nx;
  logic [DBIT-1:0] rx_b, rx_b_nx;
  logic            rx_par, rx_par_nx;
  logic            rx_done;
  logic            rx_par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_tick  <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_tick  <= rx_tick_nx;
      rx_n     <= rx_n_nx;
      rx_b     <= rx_b_nx;
      rx_par   <= rx_par_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_tick_nx  = rx_tick;
    rx_n_nx     = rx_n;
    rx_b_nx     = rx_b;
    rx_par_nx   = rx_par;
    rx_done     = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = ST_START;
          rx_tick_nx  = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (rx_tick == TICK_MID) begin
            if (rx_s) begin
              rx_state_nx = ST_IDLE;
            end else begin
              rx_state_nx = ST_DATA;
              rx_tick_nx  = '0;
              rx_n_nx     = '0;
            end
          end else begin
            rx_tick_nx = rx_tick + 6'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (rx_tick == TICK_END) begin
            rx_tick_nx = '0;
            rx_b_nx    = {rx_s, rx_b[DBIT-1:1]};
            if (rx_n == BIT_LAST) rx_state_nx = (PARITY != 0) ? ST_PAR : ST_STOP;
            else                  rx_n_nx     = rx_n + 3'd1;
          end else begin
            rx_tick_nx = rx_tick + 6'd1;
          end
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (rx_tick == TICK_END) begin
            rx_tick_nx  = '0;
            rx_par_nx   = rx_s;
            rx_state_nx = ST_STOP;
          end else begin
            rx_tick_nx = rx_tick + 6'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (rx_tick == TICK_STOP) begin
            rx_state_nx = ST_IDLE;
            rx_done     = 1'b1;
          end else begin
            rx_tick_nx = rx_tick + 6'd1;
          end
        end
      end
      default: rx_state_nx = ST_IDLE;
    endcase
  end

  assign rx_par_bad = (PARITY != 0) && (rx_par != par_of(rx_b));

  // the word is kept even when flagged; only a full FIFO drops it
  assign f_wr[0]  = rx_done && !f_full[0];
  assign f_din[0] = rx_b;
  assign f_rd[0]  = rd_uart;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (rx_done && !rx_s)      frame_err   <= 1'b1;
      else if (clr_err)          frame_err   <= 1'b0;
      if (rx_done && rx_par_bad) parity_err  <= 1'b1;
      else if (clr_err)          parity_err  <= 1'b0;
      if (rx_done && f_full[0])  overrun_err <= 1'b1;
      else if (clr_err)          overrun_err <= 1'b0;
    end
  end

  // transmitter
  state_t          tx_state, tx_state_nx;
  logic [5:0]      tx_tick, tx_tick_nx;
  logic [2:0]      tx_n, tx_n_nx;
  logic [DBIT-1:0] tx_b, tx_b_nx;
  logic            tx_par, tx_par_nx;
  logic            tx_done;
  logic            tx_bit;
  logic            tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_tick  <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_tick  <= tx_tick_nx;
      tx_n     <= tx_n_nx;
      tx_b     <= tx_b_nx;
      tx_par   <= tx_par_nx;
      tx_q     <= tx_bit;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_tick_nx  = tx_tick;
    tx_n_nx     = tx_n;
    tx_b_nx     = tx_b;
    tx_par_nx   = tx_par;
    tx_done     = 1'b0;
    tx_bit      = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        if (s_tick && !f_empty[1]) begin
          tx_state_nx = ST_START;
          tx_tick_nx  = '0;
          tx_b_nx     = f_head[1];
          tx_par_nx   = par_of(f_head[1]);
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (s_tick) begin
          if (tx_tick == TICK_END) begin
            tx_state_nx = ST_DATA;
            tx_tick_nx  = '0;
            tx_n_nx     = '0;
          end else begin
            tx_tick_nx = tx_tick + 6'd1;
          end
        end
      end
      ST_DATA: begin
        tx_bit = tx_b[0];
        if (s_tick) begin
          if (tx_tick == TICK_END) begin
            tx_tick_nx = '0;
            tx_b_nx    = {1'b0, tx_b[DBIT-1:1]};
            if (tx_n == BIT_LAST) tx_state_nx = (PARITY != 0) ? ST_PAR : ST_STOP;
            else                  tx_n_nx     = tx_n + 3'd1;
          end else begin
            tx_tick_nx = tx_tick + 6'd1;
          end
        end
      end
      ST_PAR: begin
        tx_bit = tx_par;
        if (s_tick) begin
          if (tx_tick == TICK_END) begin
            tx_tick_nx  = '0;
            tx_state_nx = ST_STOP;
          end else begin
            tx_tick_nx = tx_tick + 6'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (tx_tick == TICK_STOP) begin
            tx_state_nx = ST_IDLE;
            tx_done     = 1'b1;
          end else begin
            tx_tick_nx = tx_tick + 6'd1;
          end
        end
      end
      default: tx_state_nx = ST_IDLE;
    endcase
  end

  // the word in flight stays at the FIFO head until its last stop tick
  assign f_wr[1]  = wr_uart;
  assign f_din[1] = w_data[DBIT-1:0];
  assign f_rd[1]  = tx_done;

  always_comb begin
    r_data            = '0;
    r_data[DBIT-1:0]  = f_head[0];
  end

  assign tx          = tx_q;
  assign rx_empty    = f_empty[0];
  assign rx_full     = f_full[0];
  assign tx_empty    = f_empty[1];
  assign tx_full     = f_full[1];
  assign tx_busy     = (tx_state != ST_IDLE);
  assign rx_busy     = (rx_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg (8 data bits, even parity, 1 stop bit, 16 clk per bit):
// expected RX words are queued when a frame is sent and compared when the DUT presents them.
module tb_uart_cfg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr = '0;
  logic        rx_in;
  logic        tx;
  logic        rd_uart = 1'b0;
  logic [7:0]  r_data;
  logic        rx_empty, rx_full;
  logic        wr_uart = 1'b0;
  logic [7:0]  w_data = '0;
  logic        tx_full, tx_empty, tx_busy, rx_busy;
  logic        frame_err, parity_err, overrun_err;
  logic        clr_err = 1'b0;
  logic        loop_en = 1'b1;
  logic        rx_drv = 1'b1;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];

  assign rx_in = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_cfg #(.DBIT(8), .PARITY(1), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_in), .tx(tx),
    .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rx_word(input string tag);
    int n = 0;
    while (rx_empty !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait"}, rx_empty, 0);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    wait_rx_word(tag);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0h expected=nothing queued", tag, r_data);
    end else begin
      e = exp_q.pop_front();
      check(tag, r_data, e);
    end
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = p;
    repeat (16) @(negedge clk);
    rx_drv = stp;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    w_data  = d;
    wr_uart = 1'b1;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx, 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [10:0] frm, frm_exp;
    int          n;
    int          tx_cnt;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_full", rx_full, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_errs", {frame_err, parity_err, overrun_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // loopback of 0xA5: capture the serial frame at mid-bit and read the word back
    d = 8'hA5;
    write_byte(d);
    exp_q.push_back(d);
    wait_tx_low("lb_start");
    frm = '0;
    repeat (8) @(negedge clk);
    frm[0] = tx;
    for (int i = 1; i < 11; i++) begin
      repeat (16) @(negedge clk);
      frm[i] = tx;
    end
    frm_exp = {1'b1, ^d, d, 1'b0};
    check("lb_frame", frm, frm_exp);
    read_check("lb_data");
    check("lb_frame_err", frame_err, 0);
    check("lb_parity_err", parity_err, 0);
    check("lb_overrun_err", overrun_err, 0);
    repeat (20) @(negedge clk);

    // parity error
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h01, 1'b0, 1'b1);
    exp_q.push_back(8'h01);
    read_check("par_data");
    check("par_err_set", parity_err, 1);
    check("par_frame_err", frame_err, 0);
    pulse_clr();
    check("par_err_clr", parity_err, 0);

    // framing error: stop bit low
    d = 8'h3C;
    send_frame(d, ^d, 1'b0);
    exp_q.push_back(d);
    read_check("frm_data");
    check("frm_err_set", frame_err, 1);
    check("frm_parity_err", parity_err, 0);
    repeat (40) @(negedge clk);
    check("frm_rx_idle", rx_busy, 0);
    check("frm_no_extra", rx_empty, 1);
    pulse_clr();
    check("frm_err_clr", frame_err, 0);

    // glitch: short low pulse is a false start
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", rx_busy, 1);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_idle", rx_busy, 0);
    check("glitch_no_word", rx_empty, 1);

    // overrun: five words into a four-deep RX FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, ^d, 1'b1);
      if (exp_q.size() < 4) exp_q.push_back(d);
    end
    check("ovr_full", rx_full, 1);
    check("ovr_err", overrun_err, 1);
    for (int i = 0; i < 4; i++) read_check("ovr_data");
    check("ovr_drained", rx_empty, 1);
    check("ovr_no_frame_err", frame_err, 0);
    pulse_clr();
    check("ovr_err_clr", overrun_err, 0);

    // TX full: five back-to-back writes, the fifth is dropped
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    tx_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      d       = 8'hC0 + 8'(i);
      w_data  = d;
      wr_uart = 1'b1;
      @(negedge clk);
      if (tx_cnt < 4) begin
        exp_q.push_back(d);
        tx_cnt++;
      end
      if (i == 2) check("txf_not_full", tx_full, 0);
      if (i == 3) check("txf_full", tx_full, 1);
    end
    wr_uart = 1'b0;
    n = 0;
    while (tx_empty !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("txf_empty", tx_empty, 1);
    check("txf_tx_idle", tx, 1);
    check("txf_not_busy", tx_busy, 0);
    for (int i = 0; i < 4; i++) read_check("txf_data");
    repeat (200) @(negedge clk);
    check("txf_no_fifth", rx_empty, 1);
    check("txf_no_overrun", overrun_err, 0);

    // reset in mid-frame
    write_byte(8'h00);
    wait_tx_low("mid_start");
    repeat (20) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_tx_empty", tx_empty, 1);
    check("mid_rst_not_busy", tx_busy, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_tx_stays_high", tx, 1);
    check("mid_rx_empty", rx_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
